// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional per-requester grant counters enabled by ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_opcode,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_y,
    output logic [3:0]         rsp_flags,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_y,
    input  logic               alu_cout,
    input  logic               alu_overflow,
    input  logic               alu_negative,
    input  logic               alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        grant_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic       ptr;
    logic       owner;
    logic [1:0] grant;
    logic       accept;
    logic       sel;
    logic       done;

    // A tie between both requesters goes to the priority pointer.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            if (req_valid == 2'b11)
                grant = ptr ? 2'b10 : 2'b01;
            else
                grant = req_valid;
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];
    assign done      = (state == RESP) && rsp_ready[owner];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_y      <= '0;
            rsp_flags  <= 4'h0;
            alu_opcode <= 4'h0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
        end else begin
            if (accept) begin
                owner      <= sel;
                alu_opcode <= sel ? req_opcode[7:4] : req_opcode[3:0];
                alu_a      <= sel ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                alu_b      <= sel ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                alu_cin    <= req_cin[sel];
            end
            if (state == EXEC) begin
                rsp_y     <= alu_y;
                rsp_flags <= {alu_cout, alu_overflow, alu_negative, alu_zero};
                rsp_valid <= owner ? 2'b10 : 2'b01;
            end
            // Result bus keeps its value after the response is taken.
            if (done) begin
                rsp_valid <= 2'b00;
                ptr       <= ~owner;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= 8'h00;
            cnt1 <= 8'h00;
        end else if (accept) begin
            if (!sel && cnt0 != 8'hFF)
                cnt0 <= cnt0 + 8'h01;
            if (sel && cnt1 != 8'hFF)
                cnt1 <= cnt1 + 8'h01;
        end
    end

    assign grant_count = {cnt1, cnt0};
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural 4-bit ALU attached.
// Vector table, directed corner sequences and a random transaction model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_opcode;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_cin;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_y;
    logic [3:0] rsp_flags;
    logic [3:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_y;
    logic       alu_cout;
    logic       alu_overflow;
    logic       alu_negative;
    logic       alu_zero;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_flags    (rsp_flags),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_y        (alu_y),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_count  (grant_count)
`endif
    );

    // 0 add, 1 sub, 2 asr, 3 and, 4 or, 5 xor, 6 not a
    // Returns {cout, overflow, negative, zero, y}.
    function automatic logic [7:0] alu_f(input logic [3:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       c);
        logic [4:0] s;
        logic [3:0] y;
        logic       co;
        logic       ov;
        s  = 5'd0;
        y  = 4'd0;
        co = 1'b0;
        ov = 1'b0;
        case (op)
            4'd0: begin
                s  = {1'b0, a} + {1'b0, b} + {4'd0, c};
                y  = s[3:0];
                co = s[4];
                ov = (a[3] == b[3]) && (y[3] != a[3]);
            end
            4'd1: begin
                s  = {1'b0, a} + {1'b0, ~b} + {4'd0, c};
                y  = s[3:0];
                co = s[4];
                ov = (a[3] != b[3]) && (y[3] != a[3]);
            end
            4'd2: y = $signed(a) >>> b[1:0];
            4'd3: y = a & b;
            4'd4: y = a | b;
            4'd5: y = a ^ b;
            4'd6: y = ~a;
            default: y = a;
        endcase
        return {co, ov, y[3], (y == 4'd0), y};
    endfunction

    always_comb begin
        {alu_cout, alu_overflow, alu_negative, alu_zero, alu_y} =
            alu_f(alu_opcode, alu_a, alu_b, alu_cin);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] op,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic c);
        req_opcode[4*r +: 4] = op;
        req_a[4*r +: 4]      = a;
        req_b[4*r +: 4]      = b;
        req_cin[r]           = c;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        int         r;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] y;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[10];

    // Single transaction from IDLE; operands are scrambled after accept.
    task automatic run_one(input vec_t v);
        logic [1:0] oh;
        oh = (v.r == 1) ? 2'b10 : 2'b01;
        set_req(v.r, v.op, v.a, v.b, v.cin);
        req_valid = oh;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("vec_ready", req_ready, oh);
        chk("vec_rsp_pre", rsp_valid, 2'b00);
        step();
        req_valid  = 2'b00;
        req_opcode = 8'($urandom);
        req_a      = 8'($urandom);
        req_b      = 8'($urandom);
        @(negedge clk);
        chk("vec_exec_ready", req_ready, 2'b00);
        chk("vec_exec_rsp", rsp_valid, 2'b00);
        chk("vec_alu_a", alu_a, v.a);
        step();
        @(negedge clk);
        chk("vec_rsp_valid", rsp_valid, oh);
        chk("vec_rsp_y", rsp_y, v.y);
        chk("vec_rsp_flags", rsp_flags, v.fl);
        rsp_ready = oh;
        step();
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("vec_rsp_drop", rsp_valid, 2'b00);
        chk("vec_y_hold", rsp_y, v.y);
        step();
    endtask

    logic       m_busy;
    logic       m_last;
    logic       m_owner;
    int         m_age;
    logic [7:0] m_exp;
    logic [1:0] exp_rdy;
    int         r_sel;

    initial begin
        tbl[0] = '{0, 4'd0, 4'b0001, 4'b0001, 1'b0, 4'b0010, 4'b0000};
        tbl[1] = '{1, 4'd2, 4'b1001, 4'b0001, 1'b0, 4'b1100, 4'b0010};
        tbl[2] = '{0, 4'd0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0110};
        tbl[3] = '{1, 4'd0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b1001};
        tbl[4] = '{0, 4'd1, 4'b0101, 4'b0101, 1'b1, 4'b0000, 4'b1001};
        tbl[5] = '{1, 4'd3, 4'b1111, 4'b0111, 1'b0, 4'b0111, 4'b0000};
        tbl[6] = '{0, 4'd5, 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b0000};
        tbl[7] = '{1, 4'd4, 4'b1010, 4'b0101, 1'b0, 4'b1111, 4'b0010};
        tbl[8] = '{0, 4'd6, 4'b1000, 4'b0000, 1'b0, 4'b0111, 4'b0000};
        tbl[9] = '{1, 4'd1, 4'b0011, 4'b0100, 1'b1, 4'b1111, 4'b0010};

        req_opcode = 8'h00;
        req_a      = 8'h00;
        req_b      = 8'h00;
        req_cin    = 2'b00;
        do_reset();

        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_y", rsp_y, 4'h0);
        chk("rst_rsp_flags", rsp_flags, 4'h0);
        chk("rst_alu_op", alu_opcode, 4'h0);
        chk("rst_alu_a", alu_a, 4'h0);
        chk("rst_alu_b", alu_b, 4'h0);
        chk("rst_alu_cin", alu_cin, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        step();

        for (int i = 0; i < 10; i++)
            run_one(tbl[i]);

        // Both valid from reset: req0, then req1, then req0 again.
        do_reset();
        set_req(0, 4'd3, 4'b1111, 4'b0111, 1'b0);
        set_req(1, 4'd5, 4'b1100, 4'b1010, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("rr_first", req_ready, 2'b01);
        step();
        @(negedge clk);
        chk("rr_exec0", req_ready, 2'b00);
        step();
        @(negedge clk);
        chk("rr_rsp0", rsp_valid, 2'b01);
        chk("rr_y0", rsp_y, 4'b0111);
        step();
        @(negedge clk);
        chk("rr_second", req_ready, 2'b10);
        step();
        step();
        @(negedge clk);
        chk("rr_rsp1", rsp_valid, 2'b10);
        chk("rr_y1", rsp_y, 4'b0110);
        step();
        @(negedge clk);
        chk("rr_third", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();

        // Response backpressure on requester 0.
        set_req(0, 4'd4, 4'b1010, 4'b0101, 1'b0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 2'b01);
            chk("bp_y", rsp_y, 4'b1111);
            chk("bp_ready", req_ready, 2'b00);
            rsp_ready = (i >= 2) ? 2'b10 : 2'b00;
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp_still", rsp_valid, 2'b01);
        step();
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("bp_release", rsp_valid, 2'b00);
        chk("bp_y_hold", rsp_y, 4'b1111);
        step();

        // Reset during EXEC discards the op and clears the pointer.
        set_req(0, 4'd6, 4'b1000, 4'b0000, 1'b0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        reset     = 1'b1;
        rsp_ready = 2'b11;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx_no_rsp", rsp_valid, 2'b00);
            chk("rx_alu_a", alu_a, 4'h0);
            step();
        end
        req_valid = 2'b11;
        @(negedge clk);
        chk("rx_ptr", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        run_one('{1, 4'd0, 4'b0011, 4'b0100, 1'b0, 4'b0111, 4'b0000});

`ifdef ALU_ARB_STATS_EN
        do_reset();
        @(negedge clk);
        chk("st_reset", grant_count, 16'h0000);
        step();
        run_one(tbl[0]);
        run_one(tbl[2]);
        run_one(tbl[4]);
        run_one(tbl[1]);
        @(negedge clk);
        chk("st_0103", grant_count, 16'h0103);
        step();
        set_req(0, 4'd0, 4'd1, 4'd1, 1'b0);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        for (int i = 0; i < 260 * 3; i++)
            step();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("st_sat", grant_count, 16'h01FF);
        step();
`endif

        // Random traffic against a transaction-level model.
        do_reset();
        m_busy = 1'b0;
        m_last = 1'b1;
        m_age  = 0;
        for (int c = 0; c < 3000; c++) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_opcode = 8'($urandom);
            req_a      = 8'($urandom);
            req_b      = 8'($urandom);
            req_cin    = 2'($urandom);
            rsp_ready  = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (!m_busy) begin
                if (req_valid == 2'b11)
                    exp_rdy = m_last ? 2'b01 : 2'b10;
                else
                    exp_rdy = req_valid;
                chk("rnd_ready", req_ready, exp_rdy);
                chk("rnd_idle_rsp", rsp_valid, 2'b00);
                if (exp_rdy != 2'b00) begin
                    m_owner = exp_rdy[1];
                    r_sel   = m_owner ? 1 : 0;
                    m_exp   = alu_f(req_opcode[4*r_sel +: 4],
                                    req_a[4*r_sel +: 4],
                                    req_b[4*r_sel +: 4],
                                    req_cin[r_sel]);
                    m_busy  = 1'b1;
                    m_age   = 0;
                end
            end else begin
                m_age++;
                chk("rnd_busy_ready", req_ready, 2'b00);
                if (m_age < 2) begin
                    chk("rnd_early_rsp", rsp_valid, 2'b00);
                end else begin
                    chk("rnd_rsp", rsp_valid, m_owner ? 2'b10 : 2'b01);
                    chk("rnd_y", rsp_y, m_exp[3:0]);
                    chk("rnd_flags", rsp_flags, m_exp[7:4]);
                    if (rsp_ready[m_owner]) begin
                        m_busy = 1'b0;
                        m_last = m_owner;
                    end
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational `alu` instance between two requesters.
- Round-robin arbitration.
- Operands latched on accept; ALU driven from registers.
- Result and flags returned over a valid/ready response channel.
- Sits between two issuing units (e.g. two test/control engines) and the single `alu #(WIDTH)` datapath.

Parameters:
WIDTH, 4, operand/result width; must match the attached ALU's parameter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  2  per-requester request valid (bit i = requester i).
req_ready  out  2  per-requester accept; combinational.
req_opcode  in  8  requester i opcode at [4i+3:4i].
req_a  in  2*WIDTH  requester i operand A at [WIDTH*i +: WIDTH].
req_b  in  2*WIDTH  requester i operand B, same packing.
req_cin  in  2  requester i carry-in.
rsp_valid  out  2  one-hot response valid to the owning requester.
rsp_ready  in  2  per-requester response accept.
rsp_y  out  WIDTH  result, shared bus.
rsp_flags  out  4  {cout, overflow, negative, zero}, shared bus.
alu_opcode  out  4  to ALU opcode.
alu_a  out  WIDTH  to ALU a.
alu_b  out  WIDTH  to ALU b.
alu_cin  out  1  to ALU cin.
alu_y  in  WIDTH  from ALU y.
alu_cout, alu_overflow, alu_negative, alu_zero  in  1 each  ALU flags.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state=IDLE, priority pointer=0, owner=0, rsp_valid=0, rsp_y=0, rsp_flags=0, alu_opcode/alu_a/alu_b/alu_cin=0.
- IDLE:
  - req_ready[i] = 1 only for the granted requester i; all other ready bits are 0.
  - Grant rule: if only one req_valid bit is set, that requester is granted. If both are set, the requester equal to the priority pointer is granted.
  - On a handshake (req_valid[i] & req_ready[i]): latch opcode/a/b/cin onto the alu_* registers, owner=i, go to EXEC.
  - With no valid request, stay in IDLE; alu_* registers hold their previous values.
- EXEC (exactly 1 cycle):
  - req_ready=0.
  - alu_* stable.
  - At the clock edge: capture alu_y into rsp_y and flags into rsp_flags, set rsp_valid[owner]=1, go to RESP.
- RESP:
  - rsp_valid[owner]=1 and rsp_y/rsp_flags are held until rsp_ready[owner]=1.
  - rsp_ready of the non-owner is ignored.
  - On rsp_ready[owner]: clear rsp_valid, set priority pointer = ~owner, go to IDLE.
  - rsp_y/rsp_flags keep their last value after rsp_valid drops.
- Latency: accept at cycle N → rsp_valid high from cycle N+2. Minimum issue interval is 3 cycles with rsp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Opcode, operand and flag semantics belong entirely to the ALU; the arbiter passes values through unmodified. No opcode decoding.
- Inputs are sampled only on the handshake cycle; changes to req_* afterwards have no effect on the in-flight op.
- Reset asserted in any state: next cycle is IDLE with reset values. An in-flight op is discarded, no response is issued, and the pointer returns to 0.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined:
  - Adds output grant_count, 16 bits; requester i counter at [8i+7:8i].
  - Counter i increments on each accepted request from requester i and saturates at 255.
  - Counters clear to 0 on reset.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
Bench attaches `alu #(4)` and uses WIDTH=4.
- Requester 0 only: opcode 0000, a=0001, b=0001 → req_ready[0]=1 the same cycle; rsp_valid[0] two cycles later; rsp_y=0010.
- Requester 1 only: opcode 0010, a=1001, b=0001 → rsp_valid[1], rsp_y=1100, rsp_flags[1] (negative)=1, rsp_flags[0] (zero)=0.
- Both valid from reset: req0 AND 1111/0111, req1 XOR 1100/1010 →
  - req0 is served first, rsp_y=0111;
  - then req1, rsp_y=0110;
  - with both held valid, the next grant goes to req0.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles with an OR 1010/0101 op →
  - rsp_valid[0] and rsp_y=1111 stay stable;
  - req_ready stays 0 throughout;
  - asserting rsp_ready[1] has no effect;
  - release completes the op.
- Reset in EXEC: issue NOT a=1000, assert reset for 1 cycle during EXEC → no rsp_valid; the next request from req1 alone completes normally with the correct result.
- With ALU_ARB_STATS_EN: 3 accepts from req0 and 1 from req1 → grant_count=16'h0103. 260 accepts from req0 → count is 255.
